// File: rtl/serial_rx_pkg.sv
// Shared types and helpers for the serial frame receiver.
package serial_rx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } rx_state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// Wrap counter: counts enabled edges 0..MAX-1, sync clear, rollover pulse on the
// enabled edge where the count is MAX-1.
module rx_bit_counter #(
  parameter int unsigned MAX = 137,
  parameter int unsigned W   = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  input  logic clr,
  output logic rollover
);

  localparam logic [W-1:0] LAST = W'(MAX - 1);

  logic [W-1:0] count;

  assign rollover = en && (count == LAST);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= (count == LAST) ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Serial-to-parallel key/address/mode frame receiver with valid/ack handshake.
// Optional even-parity trailer bit enabled by SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx
  import serial_rx_pkg::*;
#(
  parameter int unsigned KEY_W  = 128,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned MODE_W = 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              shift_enable,
  input  logic              serial_in,
  input  logic              frame_start,
  input  logic              out_ack,
  output logic [KEY_W-1:0]  key,
  output logic [ADDR_W-1:0] address,
  output logic [MODE_W-1:0] mode,
  output logic              frame_valid,
  output logic              busy,
  output logic              overrun,
  output logic              parity_err
);

  localparam int unsigned FRAME_W = KEY_W + ADDR_W + MODE_W;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam int unsigned FLEN = FRAME_W + 1;
`else
  localparam int unsigned FLEN = FRAME_W;
`endif
  localparam int unsigned CNT_W = cnt_width(FLEN);

  // Only FLEN-1 bits are stored; the completing bit is taken straight from serial_in.
  logic [FLEN-2:0]    sr;
  logic [FLEN-1:0]    frame_next;
  logic [FRAME_W-1:0] data;
  logic               advance;
  logic               complete;
  logic               load;
  rx_state_t          state;

  assign advance    = shift_enable && !frame_start;
  assign frame_next = {sr, serial_in};
  assign load       = complete && (!frame_valid || out_ack);
  assign busy       = (state == SHIFT);

`ifdef SERIAL_FRAME_RX_PARITY_EN
  assign data = frame_next[FLEN-1:1];
`else
  assign data = frame_next;
`endif

  rx_bit_counter #(
    .MAX (FLEN),
    .W   (CNT_W)
  ) u_bit_counter (
    .clk      (clk),
    .n_rst    (n_rst),
    .en       (advance),
    .clr      (frame_start),
    .rollover (complete)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sr <= '0;
    end else if (frame_start) begin
      sr <= '0;
    end else if (shift_enable) begin
      sr <= frame_next[FLEN-2:0];
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state       <= IDLE;
      key         <= '0;
      address     <= '0;
      mode        <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (frame_start) begin
        state <= IDLE;
      end else if (shift_enable) begin
        state <= complete ? IDLE : SHIFT;
      end

      if (load) begin
        key         <= data[FRAME_W-1 -: KEY_W];
        address     <= data[ADDR_W+MODE_W-1 -: ADDR_W];
        mode        <= data[MODE_W-1:0];
        frame_valid <= 1'b1;
        overrun     <= 1'b0;
      end else if (complete) begin
        overrun <= 1'b1;
      end else if (out_ack && frame_valid) begin
        frame_valid <= 1'b0;
        overrun     <= 1'b0;
      end
    end
  end

`ifdef SERIAL_FRAME_RX_PARITY_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parity_err <= 1'b0;
    end else if (load) begin
      parity_err <= ^frame_next;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed self-checking bench for serial_frame_rx (default parameters).
module tb_serial_frame_rx;

  localparam int FRAME_W = 137;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam int FLEN = FRAME_W + 1;
`else
  localparam int FLEN = FRAME_W;
`endif

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         shift_enable = 1'b0;
  logic         serial_in = 1'b0;
  logic         frame_start = 1'b0;
  logic         out_ack = 1'b0;
  logic [127:0] key;
  logic [7:0]   address;
  logic [0:0]   mode;
  logic         frame_valid;
  logic         busy;
  logic         overrun;
  logic         parity_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_frame_rx #(
    .KEY_W  (128),
    .ADDR_W (8),
    .MODE_W (1)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .shift_enable (shift_enable),
    .serial_in    (serial_in),
    .frame_start  (frame_start),
    .out_ack      (out_ack),
    .key          (key),
    .address      (address),
    .mode         (mode),
    .frame_valid  (frame_valid),
    .busy         (busy),
    .overrun      (overrun),
    .parity_err   (parity_err)
  );

  localparam logic [127:0] KEY_A = 128'h6c756b65696d796f7572666174686572;
  localparam logic [127:0] KEY_B = 128'h0123456789abcdeffedcba9876543210;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [FLEN-1:0] mk(input logic [127:0] k, input logic [7:0] a, input logic m);
    logic [FRAME_W-1:0] d;
    d = {k, a, m};
`ifdef SERIAL_FRAME_RX_PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends n bits of f starting at bit index first, going down, one per clock.
  task automatic send_bits(input logic [FLEN-1:0] f, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      shift_enable = 1'b1;
      serial_in    = f[first-i];
      tick();
    end
    shift_enable = 1'b0;
    serial_in    = 1'b0;
  endtask

  task automatic ack();
    out_ack = 1'b1;
    tick();
    out_ack = 1'b0;
  endtask

  logic [FLEN-1:0] fa, ff0, f0f, fb;

  initial begin
    fa  = mk(KEY_A, 8'hF0, 1'b1);
    ff0 = mk(KEY_B, 8'hF0, 1'b0);
    f0f = mk(KEY_A, 8'h0F, 1'b1);
    fb  = mk(KEY_B, 8'h0F, 1'b0);

    // Reset state
    #12;
    check("rst_valid", frame_valid, 1'b0);
    check("rst_key", key, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_parity", parity_err, 1'b0);
    n_rst = 1'b1;
    tick();

    // Contiguous frame
    send_bits(fa, FLEN-1, FLEN-1);
    check("a_valid_early", frame_valid, 1'b0);
    check("a_busy_mid", busy, 1'b1);
    send_bits(fa, 0, 1);
    check("a_valid", frame_valid, 1'b1);
    check("a_key", key, KEY_A);
    check("a_addr", address, 8'hF0);
    check("a_mode", mode, 1'b1);
    check("a_busy", busy, 1'b0);
    check("a_overrun", overrun, 1'b0);
    check("a_parity", parity_err, 1'b0);
    ack();
    check("a_ack_valid", frame_valid, 1'b0);

    // Same frame with gaps after bit 40 and bit 130
    send_bits(fa, FLEN-1, 40);
    for (int g = 0; g < 5; g++) begin
      tick();
      check("gap1_busy", busy, 1'b1);
    end
    send_bits(fa, FLEN-41, 90);
    for (int g = 0; g < 5; g++) begin
      tick();
      check("gap2_busy", busy, 1'b1);
    end
    check("gap_valid_early", frame_valid, 1'b0);
    send_bits(fa, FLEN-131, FLEN-130);
    check("gap_valid", frame_valid, 1'b1);
    check("gap_key", key, KEY_A);
    check("gap_addr", address, 8'hF0);
    check("gap_mode", mode, 1'b1);
    check("gap_busy", busy, 1'b0);
    ack();

    // Back-to-back without ack: overrun, held outputs stay
    send_bits(ff0, FLEN-1, FLEN);
    send_bits(f0f, FLEN-1, FLEN);
    check("ovr_valid", frame_valid, 1'b1);
    check("ovr_addr", address, 8'hF0);
    check("ovr_key", key, KEY_B);
    check("ovr_flag", overrun, 1'b1);
    ack();
    check("ovr_ack_valid", frame_valid, 1'b0);
    check("ovr_ack_flag", overrun, 1'b0);

    // Completion on the same edge as ack
    send_bits(ff0, FLEN-1, FLEN);
    send_bits(f0f, FLEN-1, FLEN-1);
    check("same_hold_addr", address, 8'hF0);
    out_ack = 1'b1;
    send_bits(f0f, 0, 1);
    out_ack = 1'b0;
    check("same_valid", frame_valid, 1'b1);
    check("same_addr", address, 8'h0F);
    check("same_key", key, KEY_A);
    check("same_overrun", overrun, 1'b0);
    ack();

    // frame_start abort after 70 bits; the sampled bit on that edge is dropped
    send_bits(fa, FLEN-1, 70);
    frame_start  = 1'b1;
    shift_enable = 1'b1;
    serial_in    = 1'b1;
    tick();
    frame_start  = 1'b0;
    shift_enable = 1'b0;
    check("abort_busy", busy, 1'b0);
    send_bits(fb, FLEN-1, FLEN-70);
    check("abort_no_valid", frame_valid, 1'b0);
    check("abort_busy_mid", busy, 1'b1);
    send_bits(fb, 69, 70);
    check("abort_valid", frame_valid, 1'b1);
    check("abort_key", key, KEY_B);
    check("abort_addr", address, 8'h0F);
    check("abort_mode", mode, 1'b0);

    // Asynchronous reset mid-frame while a frame is held
    send_bits(fa, FLEN-1, 100);
    n_rst = 1'b0;
    #1;
    check("arst_valid", frame_valid, 1'b0);
    check("arst_key", key, '0);
    check("arst_addr", address, 8'h00);
    check("arst_busy", busy, 1'b0);
    #3;
    n_rst = 1'b1;
    tick();
    send_bits(fb, FLEN-1, FLEN);
    check("post_rst_valid", frame_valid, 1'b1);
    check("post_rst_key", key, KEY_B);
    ack();

`ifdef SERIAL_FRAME_RX_PARITY_EN
    fa[0] = ~fa[0];
    send_bits(fa, FLEN-1, FLEN);
    check("par_valid", frame_valid, 1'b1);
    check("par_err", parity_err, 1'b1);
    check("par_key", key, KEY_A);
    ack();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
Parametrised serial-to-parallel frame receiver. Successor to the fixed 137-bit info receiver.
- Shifts in a key, address and mode frame MSB-first, with configurable field widths.
- Presents the frame in registered, field-split form with a valid/ack handshake and overrun detection.
- Feeds the AES core's key and control loading.

Parameters:
- KEY_W, 128, key field width in bits (≥1)
- ADDR_W, 8, address field width in bits (≥1)
- MODE_W, 1, mode field width in bits (≥1)
- FRAME_W (derived, not overridable), KEY_W+ADDR_W+MODE_W, data bits per frame

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- shift_enable  in  1  sample serial_in on this edge
- serial_in  in  1  serial data, MSB of key first
- frame_start  in  1  sync abort/resync; discards partial frame
- out_ack  in  1  consumer accepts held frame
- key  out  KEY_W  received key
- address  out  ADDR_W  received address
- mode  out  MODE_W  received mode
- frame_valid  out  1  key/address/mode hold an unacked frame
- busy  out  1  partial frame in progress (bit count ≠ 0)
- overrun  out  1  sticky: frame completed while previous one unacked
- parity_err  out  1  parity result of held frame (see Optional Feature)

Behaviour:
- Reset (async, n_rst=0): shift register, bit count, key, address, mode, frame_valid, busy, overrun and parity_err are all 0. State is IDLE.
- FSM states:
  - IDLE: count=0.
  - SHIFT: 0<count<FLEN, where FLEN=FRAME_W (or FRAME_W+1 with parity).
  - IDLE→SHIFT on the first sampled bit.
  - SHIFT→IDLE on the edge sampling bit FLEN-1, or on frame_start.
- Shifting: on an edge with shift_enable=1, the shift register shifts left with serial_in entering the LSB, and count increments.
  - shift_enable=0 holds everything; gaps of any length are allowed mid-frame.
- Field mapping at completion (data part of shift register, FRAME_W bits):
  - key = [FRAME_W-1 -: KEY_W]
  - address = next ADDR_W bits
  - mode = lowest MODE_W bits
- Completion edge (the edge sampling the last bit):
  - count returns to 0.
  - If frame_valid=0 or out_ack=1: fields load, and frame_valid=1 from the next cycle. Latency is one clock after the last bit is sampled.
  - If frame_valid=1 and out_ack=0: the new frame is dropped, outputs are unchanged, and overrun←1.
- Back-to-back frames: the first bit of the next frame may be sampled on the edge immediately after completion; no idle gap is required.
- Handshake: out_ack with frame_valid=1 clears frame_valid and overrun on that edge, unless a completion occurs on the same edge, in which case frame_valid stays 1 with the new data. out_ack with frame_valid=0 is ignored.
- frame_start=1:
  - Clears count and the shift register; the serial bit on that edge is discarded even if shift_enable=1.
  - Does not affect frame_valid, the held fields or overrun.
- Held outputs are stable while frame_valid=1, until ack or reset.
- Reset mid-frame: the partial frame and any held frame are lost, and all outputs return to 0.
- busy is registered: it is 1 exactly when count≠0.

Optional Feature:
Macro SERIAL_FRAME_RX_PARITY_EN.
- Defined:
  - FLEN=FRAME_W+1; the final serial bit is an even-parity bit over the frame.
  - On load, parity_err = XOR of all FLEN bits (1 means error); it is held with the fields.
  - The frame still loads and frame_valid asserts regardless of parity_err.
- Undefined: FLEN=FRAME_W, and parity_err is tied to 0.

Decomposition:
- Package serial_rx_pkg holds:
  - state enum rx_state_t {IDLE, SHIFT}
  - function cnt_width(n) returning $clog2(n+1), used to size the bit counter
- One sub-module, rx_bit_counter: parametrised wrap counter with enable, sync clear and a rollover pulse at FLEN-1.
- Shift register, field split and handshake stay in serial_frame_rx.

Test Plan:
- Default params, shift key=128'h6c756b65696d796f7572666174686572, address=8'hF0, mode=1 contiguously (137 edges) → frame_valid=1 one cycle after the last bit; key, address and mode equal the sent values; busy=0; overrun=0.
- Same frame with shift_enable deasserted for 5 cycles after bit 40 and after bit 130 → identical outputs; busy=1 throughout the gaps.
- Two back-to-back frames (address F0 then 0F) without acking the first → outputs stay F0 and overrun=1. After out_ack: frame_valid=0, overrun=0.
- Second frame completing on the same edge as out_ack → frame_valid stays 1 and address=8'h0F; overrun=0.
- frame_start pulsed after 70 bits, then a full new frame → only the new frame is presented; no spurious frame_valid after 137 total edges.
- n_rst asserted after 100 bits → all outputs 0 immediately (asynchronously). With SERIAL_FRAME_RX_PARITY_EN and a wrong parity bit → frame_valid=1 and parity_err=1.
